// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes and fetch PC state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_RET = 2'd1,
        HALTED   = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_predict_unit_ras_stack.sv
// Return-address stack: circular buffer whose top pointer wraps modulo RAS_DEPTH.
// A push onto a full stack overwrites the oldest entry; a flush only clears the count.
module ras_stack #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 8,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  ptr_inc_s;
    logic [PTR_W-1:0]  ptr_dec_s;
    logic              do_push_s;
    logic              do_pop_s;

    assign ptr_inc_s = ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    assign ptr_dec_s = ptr_r - {{(PTR_W-1){1'b0}}, 1'b1};
    assign top_data  = mem_r[ptr_r];
    assign count     = count_r;

    // Resolve the single stack operation for this cycle; flush beats push beats pop.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else if (push) begin
            do_push_s = 1'b1;
        end else if (pop && (count_r != {CNT_W{1'b0}})) begin
            do_pop_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end
    end

    // Entry storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push_s && !reset) begin
            mem_r[ptr_inc_s] <= push_data;
        end
    end

    // Top pointer and occupancy count, saturating at RAS_DEPTH on push.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r   <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
        end else if (do_push_s) begin
            ptr_r <= ptr_inc_s;
            if (count_r != FULL_CNT) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (do_pop_s) begin
            ptr_r   <= ptr_dec_s;
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register and next-PC predictor: jXX predicted taken, call/ret via the RAS,
// redirects from write-back (ret) and memory (jXX), stall on unknown ret target, hold on halt.
module pc_predict_unit
    import y86_pkg::*;
#(
    parameter int              ADDR_W    = 64,
    parameter int              RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    localparam int             CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              f_valid,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic              m_mispredict,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic              w_ret_valid,
    input  logic              w_ret_predicted,
    input  logic [ADDR_W-1:0] w_ret_pred,
    input  logic [ADDR_W-1:0] w_valM,
    output logic [ADDR_W-1:0] pc,
    output logic              ret_stall,
    output logic              halted,
    output logic [CNT_W-1:0]  ras_count
);

    pc_state_t         state_r;
    pc_state_t         state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic              ret_stall_r;
    logic              halted_r;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic              w_fire_s;
    logic              w_miss_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic [CNT_W-1:0]  ras_count_s;

    // An unpredicted ret always redirects; a predicted one only when the guess was wrong.
    assign w_miss_s = w_ret_predicted && (w_ret_pred != w_valM);
    assign w_fire_s = w_ret_valid && (!w_ret_predicted || (w_ret_pred != w_valM));

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .push_data (f_valP),
        .top_data  (ras_top_s),
        .count     (ras_count_s)
    );

    // Priority mux: W redirect, M redirect, hold, then icode-based prediction.
    always_comb begin
        pc_nxt_s    = pc_r;
        state_nxt_s = state_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        if (w_fire_s) begin
            pc_nxt_s    = w_valM;
            state_nxt_s = RUN;
            flush_s     = w_miss_s;
        end else if (m_mispredict) begin
            pc_nxt_s    = m_valA;
            state_nxt_s = RUN;
            flush_s     = 1'b1;
        end else if (stall || (state_r != RUN) || !f_valid) begin
            pc_nxt_s    = pc_r;
            state_nxt_s = state_r;
        end else begin
            case (f_icode)
                IJXX: begin
                    pc_nxt_s = f_valC;
                end
                ICALL: begin
                    pc_nxt_s = f_valC;
                    push_s   = 1'b1;
                end
                IRET: begin
                    if (ras_count_s != {CNT_W{1'b0}}) begin
                        pc_nxt_s = ras_top_s;
                        pop_s    = 1'b1;
                    end else begin
                        pc_nxt_s    = pc_r;
                        state_nxt_s = WAIT_RET;
                    end
                end
                IHALT: begin
                    pc_nxt_s    = pc_r;
                    state_nxt_s = HALTED;
                end
                default: begin
                    pc_nxt_s = f_valP;
                end
            endcase
        end
    end

    // PC, FSM state and the registered status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            state_r     <= RUN;
            ret_stall_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            pc_r        <= pc_nxt_s;
            state_r     <= state_nxt_s;
            ret_stall_r <= (state_nxt_s == WAIT_RET);
            halted_r    <= (state_nxt_s == HALTED);
        end
    end

    assign pc        = pc_r;
    assign ret_stall = ret_stall_r;
    assign halted    = halted_r;
    assign ras_count = ras_count_s;

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Fetch-stage PC register and next-PC predictor for the pipelined Y86-64 core; the pipelined successor to the sequential PC update logic.
- Predicts every control transfer:
  - jXX predicted taken.
  - call and ret handled through a parametrised return-address stack (RAS).
- Accepts redirects from the memory stage (jXX mispredict) and write-back stage (ret target resolution or ret mispredict).
- Stalls fetch while a ret target is unknown, and holds on halt.

Parameters:
- ADDR_W, 64, width of all addresses and PC values.
- RAS_DEPTH, 8, RAS entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from pipeline control; holds PC and RAS.
- f_valid  input  1  fetch stage holds a decoded instruction this cycle.
- f_icode  input  4  icode of the fetched instruction.
- f_valC  input  ADDR_W  fetched constant (jump or call target).
- f_valP  input  ADDR_W  fall-through address of the fetched instruction.
- m_mispredict  input  1  jXX in memory stage resolved not-taken.
- m_valA  input  ADDR_W  correct fall-through PC for m_mispredict.
- w_ret_valid  input  1  ret in write-back with resolved target.
- w_ret_predicted  input  1  that ret was RAS-predicted.
- w_ret_pred  input  ADDR_W  target the RAS predicted for that ret.
- w_valM  input  ADDR_W  actual return address popped from memory.
- pc  output  ADDR_W  registered fetch PC.
- ret_stall  output  1  fetch must insert bubbles (state WAIT_RET).
- halted  output  1  fetch stopped on halt (state HALTED).
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset values:
  - pc=RESET_PC, state=RUN, ras_count=0.
  - ret_stall=0, halted=0.
  - RAS contents don't-care.
- States:
  - RUN: normal fetch.
  - WAIT_RET: a ret was fetched with an empty RAS.
  - HALTED: halt fetched.
- All outputs are registered state; ret_stall = (state==WAIT_RET), halted = (state==HALTED).
- Per-cycle priority, highest first:
  1. reset.
  2. W redirect.
  3. M redirect.
  4. Hold.
  5. Predict.
- W redirect:
  - Fires when w_ret_valid and (!w_ret_predicted or w_ret_pred != w_valM).
  - pc<=w_valM, state<=RUN.
  - On mismatch, also flush RAS (count<=0).
  - A correctly predicted ret (w_ret_predicted and equal) causes no action.
- M redirect (m_mispredict): pc<=m_valA, state<=RUN, RAS flushed.
- Redirects override stall, HALTED and WAIT_RET; a speculative halt or ret is discarded.
- Hold: stall=1, or state!=RUN, or f_valid=0 → pc and RAS unchanged.
- Predict (RUN, f_valid, !stall), by f_icode:
  - 7 (jXX): pc<=f_valC.
  - 8 (call): pc<=f_valC; push f_valP.
  - 9 (ret), count>0: pop; pc<=popped entry.
  - 9 (ret), count==0: pc unchanged; state<=WAIT_RET.
  - 0 (halt): pc unchanged; state<=HALTED.
  - All others: pc<=f_valP.
- RAS behaviour:
  - Circular buffer with top pointer wrapping modulo RAS_DEPTH.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop decrements count and pointer.
  - At most one push or pop per cycle.
  - A flush clears count only.
- Wrap-around: PC arithmetic is never performed here (valP supplied), so no overflow handling is needed.
- Reset during WAIT_RET or HALTED returns to RUN at RESET_PC next cycle.

Decomposition:
- y86_pkg holds:
  - icode constants: IHALT=4'h0, IJXX=4'h7, ICALL=4'h8, IRET=4'h9.
  - pc_state_t enum {RUN, WAIT_RET, HALTED}.
- Sub-module ras_stack holds the RAS:
  - Parameters ADDR_W, RAS_DEPTH.
  - Ports push, pop, flush, push_data, top_data, count.
  - Synchronous reset.
- Top module holds the FSM, priority mux and PC register.

Test Plan:
1. Reset then call, call, ret, ret sequence:
   - Reset with RESET_PC=0x100.
   - call valC=0x200/valP=0x109 → pc=0x200, count=1.
   - call valC=0x300/valP=0x209 → pc=0x300, count=2.
   - ret → pc=0x209, count=1.
   - ret → pc=0x109, count=0.
2. Ret on empty RAS:
   - ret with count=0 → ret_stall=1, pc held.
   - Next cycle, w_ret_valid, w_ret_predicted=0, w_valM=0x450 → pc=0x450, ret_stall=0.
3. jXX mispredict:
   - jXX valC=0x500 → pc=0x500.
   - m_mispredict with m_valA=0x10A while stall=1 and a call is fetched → pc=0x10A, count=0, no push.
4. RAS overflow with RAS_DEPTH=4:
   - 5 calls with valP 0x10..0x50 → count=4.
   - 4 rets → pc 0x50, 0x40, 0x30, 0x20.
   - 5th ret → WAIT_RET.
5. Ret mispredict:
   - w_ret_valid, w_ret_predicted=1, w_ret_pred=0x600, w_valM=0x700, concurrent with m_mispredict m_valA=0x800 → pc=0x700, RAS flushed.
6. Halt and recovery:
   - halt → halted=1, pc held over 3 cycles of other icodes.
   - m_mispredict m_valA=0x120 → halted=0, pc=0x120.
   - Reset mid-WAIT_RET → pc=RESET_PC, state RUN.
